// File: rtl/nn_cls_pkg.sv
// Shared types and constants for the streaming argmax classifier.
package nn_cls_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        CLS_IDLE  = 2'd0,
        CLS_ACCUM = 2'd1,
        CLS_DONE  = 2'd2
    } cls_state_e;

    // Bit pattern of the most negative two's-complement value of the given width.
    function automatic logic [63:0] cls_min_score(input int unsigned data_w);
        return 64'd1 << (data_w - 1);
    endfunction

endpackage

// File: rtl/cls_onehot_decode.sv
// Index to one-hot decoder with byte slicer; purely combinational.
module cls_onehot_decode
    import nn_cls_pkg::*;
#(
    parameter int unsigned NODES = 16,
    parameter int unsigned IDX_W = $clog2(NODES),
    parameter int unsigned SEL_W = 1
) (
    input  logic               en_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [SEL_W-1:0]   byte_sel_i,
    output logic [NODES-1:0]   onehot_o,
    output logic [BYTE_W-1:0]  byte_o
);

    localparam int unsigned NBYTES = NODES / BYTE_W;

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NODES; i++) begin
            onehot_o[i] = en_i && (idx_i == IDX_W'(i));
        end
    end

    // Selects that name no existing byte leave the output at zero.
    always_comb begin
        byte_o = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (byte_sel_i == SEL_W'(b)) begin
                byte_o = onehot_o[b*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/stream_argmax_classifier.sv
// Streaming argmax over one job of signed scores with valid/ready in and out.
// Optional RUNNER_UP_EN adds second-best index and best-minus-second margin.
module stream_argmax_classifier
    import nn_cls_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_NODES = 16,
    localparam int unsigned IDX_W    = $clog2(MAX_NODES),
    localparam int unsigned SEL_W    = (MAX_NODES / 8 > 1) ? $clog2(MAX_NODES / 8) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [IDX_W:0]           num_nodes,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_score,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         class_idx,
    output logic [MAX_NODES-1:0]     class_onehot,
    input  logic [SEL_W-1:0]         byte_sel,
    output logic [BYTE_W-1:0]        class_byte,
    output logic signed [DATA_W-1:0] max_score
`ifdef RUNNER_UP_EN
    ,
    output logic [IDX_W-1:0]         second_idx,
    output logic [DATA_W:0]          margin
`endif
);

    localparam logic signed [DATA_W-1:0] MIN_S = DATA_W'(cls_min_score(DATA_W));
    localparam logic [IDX_W:0]           MAX_N = (IDX_W + 1)'(MAX_NODES);

    cls_state_e                state_q, state_d;
    logic [IDX_W:0]            n_q, n_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  best_q, best_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;
    logic                      busy_q, busy_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [IDX_W-1:0]          class_idx_q, class_idx_d;
    logic signed [DATA_W-1:0]  max_score_q, max_score_d;
    logic                      res_vld_q, res_vld_d;

    logic                      accept;
    logic                      last_beat;
    logic                      take;
    logic signed [DATA_W-1:0]  best_nxt;
    logic [IDX_W-1:0]          idx_nxt;
    logic [IDX_W:0]            n_clamped;

`ifdef RUNNER_UP_EN
    logic signed [DATA_W-1:0]  sec_q, sec_d;
    logic [IDX_W-1:0]          sec_idx_q, sec_idx_d;
    logic [IDX_W-1:0]          second_idx_q, second_idx_d;
    logic [DATA_W:0]           margin_q, margin_d;
    logic signed [DATA_W-1:0]  sec_nxt;
    logic [IDX_W-1:0]          sec_idx_nxt;
    logic [DATA_W:0]           margin_nxt;
`endif

    assign accept    = in_ready_q && in_valid;
    assign last_beat = ((IDX_W + 1)'(cnt_q)) == (n_q - (IDX_W + 1)'(1));
    assign take      = in_score >= best_q;
    assign best_nxt  = take ? in_score : best_q;
    assign idx_nxt   = take ? cnt_q : best_idx_q;
    assign n_clamped = ((num_nodes == '0) || (num_nodes > MAX_N)) ? MAX_N : num_nodes;

`ifdef RUNNER_UP_EN
    // The displaced best becomes runner-up; otherwise a score between the two replaces it.
    always_comb begin
        sec_nxt     = sec_q;
        sec_idx_nxt = sec_idx_q;
        if (take) begin
            sec_nxt     = best_q;
            sec_idx_nxt = best_idx_q;
        end else if (in_score >= sec_q) begin
            sec_nxt     = in_score;
            sec_idx_nxt = cnt_q;
        end
    end

    assign margin_nxt = {best_nxt[DATA_W-1], best_nxt} - {sec_nxt[DATA_W-1], sec_nxt};
`endif

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        res_vld_d   = res_vld_q;
`ifdef RUNNER_UP_EN
        sec_d        = sec_q;
        sec_idx_d    = sec_idx_q;
        second_idx_d = second_idx_q;
        margin_d     = margin_q;
`endif
        case (state_q)
            CLS_IDLE: begin
                if (start) begin
                    state_d    = CLS_ACCUM;
                    n_d        = n_clamped;
                    cnt_d      = '0;
                    best_d     = MIN_S;
                    best_idx_d = '0;
`ifdef RUNNER_UP_EN
                    sec_d     = MIN_S;
                    sec_idx_d = '0;
`endif
                end
            end
            CLS_ACCUM: begin
                if (accept) begin
                    best_d     = best_nxt;
                    best_idx_d = idx_nxt;
                    cnt_d      = cnt_q + IDX_W'(1);
`ifdef RUNNER_UP_EN
                    sec_d     = sec_nxt;
                    sec_idx_d = sec_idx_nxt;
`endif
                    if (last_beat) begin
                        state_d     = CLS_DONE;
                        cnt_d       = '0;
                        class_idx_d = idx_nxt;
                        max_score_d = best_nxt;
                        res_vld_d   = 1'b1;
`ifdef RUNNER_UP_EN
                        second_idx_d = (n_q == (IDX_W + 1)'(1)) ? '0 : sec_idx_nxt;
                        margin_d     = (n_q == (IDX_W + 1)'(1)) ? '0 : margin_nxt;
`endif
                    end
                end
            end
            CLS_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = CLS_IDLE;
                end
            end
            default: state_d = CLS_IDLE;
        endcase
        busy_d      = (state_d != CLS_IDLE);
        in_ready_d  = (state_d == CLS_ACCUM);
        out_valid_d = (state_d == CLS_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLS_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            class_idx_q <= '0;
            max_score_q <= '0;
            res_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
            res_vld_q   <= res_vld_d;
        end
    end

`ifdef RUNNER_UP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_q        <= '0;
            sec_idx_q    <= '0;
            second_idx_q <= '0;
            margin_q     <= '0;
        end else begin
            sec_q        <= sec_d;
            sec_idx_q    <= sec_idx_d;
            second_idx_q <= second_idx_d;
            margin_q     <= margin_d;
        end
    end

    assign second_idx = second_idx_q;
    assign margin     = margin_q;
`endif

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;
    assign max_score = max_score_q;

    // One-hot stays zero until the first result after reset.
    cls_onehot_decode #(
        .NODES (MAX_NODES),
        .IDX_W (IDX_W),
        .SEL_W (SEL_W)
    ) u_decode (
        .en_i       (res_vld_q),
        .idx_i      (class_idx_q),
        .byte_sel_i (byte_sel),
        .onehot_o   (class_onehot),
        .byte_o     (class_byte)
    );

endmodule

// File: doc/stream_argmax_classifier.md
Name: stream_argmax_classifier

Overview:
- Sequential, parametrised successor to the combinational 16-way argmax classifier.
- Accepts a job's signed output-layer scores one per accepted beat (valid/ready) and tracks the running maximum and its index.
- Presents the winning class as index, one-hot word and byte-sliced one-hot through a valid/ready result port.
- Sits between the NN output layer and the memory-mapped write path of the ARM core.

Parameters:
- DATA_W, 8: score width, signed two's complement.
- MAX_NODES, 16: maximum classes per job; must be a multiple of 8 and at least 8.
- IDX_W, $clog2(MAX_NODES): class index width (derived, do not override).
- SEL_W, max(1,$clog2(MAX_NODES/8)): byte-select width (derived).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job start; samples num_nodes.
- num_nodes  in  IDX_W+1  class count for the job, 1..MAX_NODES; 0 or >MAX_NODES clamps to MAX_NODES.
- busy  out  1  high from accepted start until result handshake completes.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a score.
- in_score  in  DATA_W  signed score, class order 0,1,2,...
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- class_idx  out  IDX_W  winning class index.
- class_onehot  out  MAX_NODES  one-hot of class_idx.
- byte_sel  in  SEL_W  selects class_onehot[8*byte_sel+7 : 8*byte_sel] (combinational).
- class_byte  out  8  selected one-hot byte; zero if byte_sel is out of range.
- max_score  out  DATA_W  winning score.

Behaviour:
- Reset (async assert, sync-released deassert): state IDLE; busy=0, in_ready=0, out_valid=0; class_idx, max_score, counters and one-hot all 0.
- FSM states IDLE, ACCUM, DONE.
- IDLE:
  - start=1 latches the clamped count into n_reg, clears count to 0, loads best_score with the most negative value (-2^(DATA_W-1)), best_idx=0.
  - Then goes to ACCUM; busy=1 from the next cycle.
- ACCUM:
  - in_ready=1.
  - Each beat with in_valid&&in_ready compares in_score against best_score. If in_score >= best_score, best_score<=in_score and best_idx<=count; a tie goes to the later (higher) index.
  - count increments on each accepted beat.
  - When the beat with count==n_reg-1 is accepted, the FSM goes to DONE.
  - Because the initial best is the minimum value, an all-minimum job returns the last index.
- DONE:
  - in_ready=0; out_valid=1 on the cycle after the last beat (latency 1 cycle from last accept).
  - Outputs are registered and stable while out_valid=1.
  - out_valid&&out_ready returns the FSM to IDLE; busy=0 on the next cycle.
- start is ignored while busy=1 (ACCUM or DONE); no restart mid-job.
- start and out_ready handshake in the same cycle in DONE: the handshake completes and start is ignored. A new job needs start in IDLE.
- in_valid while in IDLE or DONE: not accepted (in_ready=0), no state change.
- Indices ≥ n_reg never enter the comparison (equivalent to masking disabled nodes).
- Count wraps only via job completion; count never exceeds n_reg-1.
- Reset asserted mid-job aborts immediately to reset values; the partial job is lost.

Optional Feature:
- RUNNER_UP_EN defined: adds outputs second_idx (IDX_W) and margin (DATA_W+1, unsigned).
  - Runner-up updates as best is demoted, or when in_score >= second but < best.
  - margin = best - second, computed at DATA_W+1 bits.
  - For n_reg==1, second_idx=0 and margin=0.
  - Reset value 0.
- RUNNER_UP_EN undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package nn_cls_pkg: FSM state enum (CLS_IDLE, CLS_ACCUM, CLS_DONE); function for the minimum signed value of DATA_W; the byte width constant 8.
- One sub-module, cls_onehot_decode: parametrised index→one-hot decoder plus byte slicer, purely combinational; instantiated once in the top.

Test Plan:
- num_nodes=16, scores 0..15 = {-5,3,7,2,-1,0,7,1,...,-128 rest} -> class_idx=6 (tie to later), max_score=7, class_onehot=0x0040, byte_sel=0 gives class_byte=0x40, byte_sel=1 gives 0x00.
- num_nodes=3, scores {10,-20,5}, then 5 extra in_valid beats -> class_idx=0, max_score=10, out_valid 1 cycle after 3rd accept, extra beats not accepted (in_ready=0).
- num_nodes=0 with MAX_NODES=16, all scores -128 -> 16 beats accepted, class_idx=15, onehot 0x8000, byte_sel=1 gives 0x80.
- Result backpressure: out_ready low 5 cycles, start pulsed during DONE -> outputs stable, start ignored, busy falls 1 cycle after out_ready.
- reset_n low after 4 of 8 beats -> all outputs 0 immediately; next job with num_nodes=2, {1,2} -> class_idx=1.
- RUNNER_UP_EN, MAX_NODES=32, scores {4,9,-3,9,...} with num_nodes=4 -> class_idx=3, second_idx=1, margin=0; second run {100,-100} -> margin=200.
